// File: rtl/lsu_ctrl.sv
// Load/store controller: captures one ALU-computed access, runs a single req/ack
// memory transaction with byte-lane steering, and returns a formatted load result.
module lsu_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req_vld,
  input  logic             i_we,
  input  logic [2:0]       i_funct3,
  input  logic [WIDTH-1:0] i_addr,
  input  logic [WIDTH-1:0] i_st_data,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [WIDTH-1:0] o_ld_data,
  output logic             o_mem_req,
  output logic             o_mem_we,
  output logic [WIDTH-1:0] o_mem_addr,
  output logic [WIDTH-1:0] o_mem_wdata,
  output logic [3:0]       o_mem_bmask,
  input  logic             i_mem_ack,
  input  logic [WIDTH-1:0] i_mem_rdata
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic [1:0]       state_reg, state_next;
  logic             we_reg;
  logic [2:0]       funct3_reg;
  logic [1:0]       off_reg;
  logic [WIDTH-1:0] addr_reg;
  logic [WIDTH-1:0] wdata_reg;
  logic [3:0]       bmask_reg;
  logic             err_reg;
  logic [WIDTH-1:0] ld_data_reg;

  logic [WIDTH-1:0] wdata_fmt;
  logic [3:0]       bmask_fmt;
  logic             err_chk;
  logic [WIDTH-1:0] ld_fmt;
  logic [7:0]       rd_lane [4];
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;

  wire accept = (state_reg == ST_IDLE) && i_req_vld;

  // Store data is steered onto every lane so the byte mask alone selects the target bytes.
  always_comb begin
    wdata_fmt = i_st_data;
    bmask_fmt = 4'b1111;
    if (i_we) begin
      case (i_funct3)
        F3_B: begin
          wdata_fmt = {4{i_st_data[7:0]}};
          bmask_fmt = 4'b0001 << i_addr[1:0];
        end
        F3_H: begin
          wdata_fmt = {2{i_st_data[15:0]}};
          bmask_fmt = i_addr[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          wdata_fmt = i_st_data;
          bmask_fmt = 4'b1111;
        end
      endcase
    end
  end

  always_comb begin
    err_chk = 1'b0;
    case (i_funct3)
      F3_B:  err_chk = 1'b0;
      F3_H:  err_chk = i_addr[0];
      F3_W:  err_chk = (i_addr[1:0] != 2'b00);
      F3_BU: err_chk = i_we;
      F3_HU: err_chk = i_we | i_addr[0];
      default: err_chk = 1'b1;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign rd_lane[gi] = i_mem_rdata[8*gi +: 8];
    end
  endgenerate

  assign rd_byte = rd_lane[off_reg];
  assign rd_half = off_reg[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];

  always_comb begin
    ld_fmt = i_mem_rdata;
    case (funct3_reg)
      F3_B:    ld_fmt = {{24{rd_byte[7]}}, rd_byte};
      F3_H:    ld_fmt = {{16{rd_half[15]}}, rd_half};
      F3_BU:   ld_fmt = {24'd0, rd_byte};
      F3_HU:   ld_fmt = {16'd0, rd_half};
      default: ld_fmt = i_mem_rdata;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (i_req_vld) state_next = err_chk ? ST_DONE : ST_REQ;
      ST_REQ:  if (i_mem_ack) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg   <= ST_IDLE;
      we_reg      <= 1'b0;
      funct3_reg  <= 3'd0;
      off_reg     <= 2'd0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      bmask_reg   <= 4'd0;
      err_reg     <= 1'b0;
      ld_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        we_reg     <= i_we;
        funct3_reg <= i_funct3;
        off_reg    <= i_addr[1:0];
        addr_reg   <= {i_addr[WIDTH-1:2], 2'b00};
        wdata_reg  <= wdata_fmt;
        bmask_reg  <= bmask_fmt;
        err_reg    <= err_chk;
      end
      // Only a completed load touches the result; stores and errors leave it intact.
      if ((state_reg == ST_REQ) && i_mem_ack && !we_reg) begin
        ld_data_reg <= ld_fmt;
      end
    end
  end

  assign o_busy      = (state_reg != ST_IDLE);
  assign o_done      = (state_reg == ST_DONE);
  assign o_err       = (state_reg == ST_DONE) && err_reg;
  assign o_ld_data   = ld_data_reg;
  assign o_mem_req   = (state_reg == ST_REQ);
  assign o_mem_we    = (state_reg == ST_REQ) && we_reg;
  assign o_mem_addr  = addr_reg;
  assign o_mem_wdata = wdata_reg;
  assign o_mem_bmask = bmask_reg;

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store controller sitting directly downstream of the ALU: it takes the effective address computed by the ALU (`o_alu_data` of an ADD), plus store data and access type from decode, and runs one data-memory transaction over a req/ack handshake with variable memory latency. It handles the following:
- byte-lane steering and byte-mask generation for stores;
- lane selection and sign/zero extension for loads;
- misalignment and illegal-type detection.

Results return to writeback with a one-cycle done pulse.

## Interface
- `WIDTH`, 32, data/address width (block is defined for 32 only)
- `i_clk`  in  1  clock, all state on rising edge
- `i_rst_n`  in  1  reset, asynchronous, active-low
- `i_req_vld`  in  1  start a transaction; sampled only in IDLE
- `i_we`  in  1  1 = store, 0 = load
- `i_funct3`  in  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU legal for loads only)
- `i_addr`  in  WIDTH  effective byte address from ALU
- `i_st_data`  in  WIDTH  store data (rs2)
- `o_busy`  out  1  high whenever state != IDLE
- `o_done`  out  1  one-cycle completion pulse
- `o_err`  out  1  valid with `o_done`: misaligned or illegal type, no memory access made
- `o_ld_data`  out  WIDTH  formatted load result
- `o_mem_req`  out  1  memory request, held until ack
- `o_mem_we`  out  1  memory write enable
- `o_mem_addr`  out  WIDTH  word-aligned address `{addr[31:2],2'b00}`
- `o_mem_wdata`  out  WIDTH  lane-replicated store data
- `o_mem_bmask`  out  4  byte enables (stores); 4'b1111 for loads
- `i_mem_ack`  in  1  memory accepts/completes; rdata valid same cycle
- `i_mem_rdata`  in  WIDTH  read word

## Operation
- FSM states: IDLE, REQ, DONE.
- **IDLE:** on `i_req_vld`, latch the following into internal registers:
  - `i_we`, `i_funct3`, `i_addr[1:0]`, word address;
  - store data and mask, formatted at capture.
- **Error check in IDLE:**
  - Error when: H/HU with `addr[0]=1`; W with `addr[1:0]!=0`; funct3 not in the legal set; BU/HU with `i_we=1`.
  - Error → DONE with `o_err=1`; no `o_mem_req` ever raised.
  - Otherwise → REQ.
- **REQ:** `o_mem_req=1`; `o_mem_we`, addr, wdata and bmask are stable from the latches. Stay in REQ until `i_mem_ack`.
- **On ack in REQ, go to DONE.**
  - Load: format `i_mem_rdata` into the `o_ld_data` register.
  - Store: `o_ld_data` unchanged.
- **DONE:** `o_done=1` for exactly one cycle; `o_err` reflects the latched error. DONE → IDLE unconditionally.
- **Store formatting:**
  - SB: wdata = byte replicated ×4, bmask = `4'b0001 << addr[1:0]`.
  - SH: wdata = halfword ×2, bmask = `addr[1]` ? 1100 : 0011.
  - SW: wdata = data, bmask = 1111.
- **Load formatting:**
  - Select byte `addr[1:0]` or halfword `addr[1]`.
  - B/H sign-extend; BU/HU zero-extend; W pass-through.
- **Load result updates:** `o_ld_data` updates only on successful load completion; it holds across stores, errors, and idle.
- **Ignored inputs:**
  - `i_req_vld` outside IDLE is ignored (not queued).
  - `i_mem_ack` outside REQ is ignored.

## Timing
- **Reset:** while `i_rst_n=0`, state = IDLE and all outputs are 0, including `o_ld_data` and `o_mem_bmask`. Reset during REQ abandons the transaction; `o_mem_req` drops asynchronously.
- **Memory outputs outside REQ:**
  - `o_mem_req` and `o_mem_we` are 0.
  - `o_mem_addr`, `o_mem_wdata` and `o_mem_bmask` hold their last latched values; the memory must not sample them without req.
- **Valid access latency:**
  - Accept in cycle 0.
  - `o_mem_req` high from cycle 1.
  - Ack in cycle 1+k (k ≥ 0).
  - `o_done` in cycle 2+k.
  - Minimum 2 cycles to done; 3 cycles between back-to-back accepts.
- **Error latency:** accept in cycle 0, `o_done`+`o_err` in cycle 1.
- **Ack timing:** ack in the first REQ cycle is legal. ack and req are both high in the completing cycle; req falls the next cycle.
- **Output timing:**
  - All outputs are registered or decoded from the state register only.
  - No combinational path from `i_mem_ack` or `i_mem_rdata` to any output.

## Test plan
- **LW with ack delay:** LW addr 0x0000_1004, ack 3 cycles after req, rdata 0xDEAD_BEEF.
  - `o_mem_addr`=0x0000_1004, bmask 1111, we 0.
  - done 5 cycles after accept, `o_ld_data`=0xDEAD_BEEF, err 0.
- **LB then LBU:**
  - LB addr 0x...03, rdata 0x80AA_BBCC → `o_ld_data`=0xFFFF_FF80.
  - LBU same → 0x0000_0080.
  - LHU addr 0x...02 → 0x0000_80AA.
- **SH with immediate ack:** SH addr 0x...06, st_data 0x1234_ABCD, ack in the first REQ cycle.
  - `o_mem_addr`=0x...04, wdata 0xABCD_ABCD, bmask 1100, we 1.
  - done 2 cycles after accept, `o_ld_data` unchanged.
- **Misaligned and illegal requests:**
  - LW addr 0x...02 → done+err 1 cycle after accept, `o_mem_req` never asserted.
  - Store with funct3=100 → same behaviour.
- **Reset mid-transaction:** reset asserted mid-REQ (ack withheld).
  - `o_mem_req`, `o_busy`, `o_ld_data` go 0 immediately.
  - After release, a fresh SB addr 0x...01, data 0xXX_XX5A → wdata 0x5A5A_5A5A, bmask 0010.
- **Request while busy:** `i_req_vld` pulsed while busy and a stray `i_mem_ack` in IDLE → no second transaction, no state change, single done pulse.
